// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: shared loader FSM states and constants for the program loader.
//   Provides state_t (loader FSM states), SYNC_BYTE_DEF (default frame marker)
//   and WORD_W (instruction word width).
package inst_mem_loader_pkg;
    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_DATA,
        S_SUM,
        S_COMMIT,
        S_RUN,
        S_ERR
    } state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int WORD_W = 32;
endpackage

// File: rtl/inst_mem_loader_word_ram.sv
// inst_word_ram: 2^ADDR_W x 32 instruction store, synchronous write, asynchronous read.
//   clk   in  clock
//   we    in  write enable
//   waddr in  write word address
//   wdata in  write word
//   raddr in  read word address
//   rdata out word at raddr (combinational)
module inst_word_ram
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: framed byte-stream program loader and instruction-memory responder.
//   clk, Rst (async, active-high)
//   rx_data/rx_valid/rx_ready : byte input handshake
//   Inst_addr/Inst_data       : combinational fetch port
//   cpu_hold                  : core reset, high except while running
//   load_done/load_err        : outcome of the last frame
//   words_loaded              : words written by the current or last frame
//   Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] Inst_addr,
    output logic [WORD_W-1:0] Inst_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [23:0]       asm_q, asm_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif
    logic              xfer, we, is_sync, len_bad, last_word;
    logic [ADDR_W:0]   len_w;

    assign rx_ready  = !Rst && state_q != S_COMMIT;
    assign xfer      = rx_valid && rx_ready;
    assign is_sync   = rx_data == SYNC_BYTE;
    // A zero length byte encodes a full store.
    assign len_w     = rx_data == 8'd0 ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(rx_data);
    assign len_bad   = 32'(rx_data) > 32'(DEPTH);
    assign last_word = words_q + (ADDR_W+1)'(1) == cnt_q;

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        lane_d  = lane_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        we      = 1'b0;
        case (state_q)
            S_SYNC: state_d = xfer && is_sync ? S_LEN : S_SYNC;
            S_LEN: begin
                if (xfer && len_bad) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (xfer) begin
                    state_d = S_DATA;
                    cnt_d   = len_w;
                    waddr_d = '0;
                    lane_d  = '0;
                    words_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d  = {rx_data, asm_q[23:8]};
                    lane_d = lane_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d  = sum_q ^ rx_data;
`endif
                    if (lane_q == 2'd3) begin
                        we      = 1'b1;
                        waddr_d = waddr_q + ADDR_W'(1);
                        words_d = words_q + (ADDR_W+1)'(1);
`ifdef INST_LOADER_CHECKSUM_EN
                        state_d = last_word ? S_SUM : S_DATA;
`else
                        state_d = last_word ? S_COMMIT : S_DATA;
`endif
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_SUM: begin
                if (xfer) begin
                    state_d = rx_data == sum_q ? S_COMMIT : S_ERR;
                    err_d   = rx_data != sum_q;
                end
            end
`endif
            S_COMMIT: begin
                state_d = S_RUN;
                done_d  = 1'b1;
                err_d   = 1'b0;
            end
            S_RUN: begin
                if (xfer && is_sync) begin
                    state_d = S_LEN;
                    done_d  = 1'b0;
                end
            end
            S_ERR: begin
                if (xfer && is_sync) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_SYNC;
            asm_q   <= '0;
            lane_q  <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            lane_q  <= lane_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign cpu_hold     = state_q != S_RUN;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

    inst_word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr_q),
        .wdata ({rx_data, asm_q}),
        .raddr (Inst_addr),
        .rdata (Inst_data)
    );
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed self-checking bench for inst_mem_loader.
module tb_inst_mem_loader;
    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [5:0]  Inst_addr = 6'd0;
    logic [31:0] Inst_data;
    logic        cpu_hold, load_done, load_err;
    logic [6:0]  words_loaded;
    logic [31:0] img [64];
    int          tests = 0;
    int          fails = 0;

    inst_mem_loader dut (
        .clk          (clk),
        .Rst          (Rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .Inst_addr    (Inst_addr),
        .Inst_data    (Inst_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, output int waits);
        waits = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!rx_ready) begin
            tests++; fails++;
            $display("FAIL handshake_timeout byte=%02h rx_ready=%b required 1", b, rx_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic sb(input logic [7:0] b);
        int w;
        send_byte(b, w);
    endtask

    // Sends A5, n, nw words from img LSB first, plus checksum when enabled; rx_valid left high.
    task automatic send_frame(input logic [7:0] n, input int nw, output int waits_total);
        int w;
        logic [7:0] sum;
        logic [31:0] word;
        sum = 8'h00;
        waits_total = 0;
        send_byte(8'hA5, w); waits_total += w;
        send_byte(n, w);     waits_total += w;
        for (int i = 0; i < nw; i++) begin
            word = img[i];
            for (int k = 0; k < 4; k++) begin
                sum ^= word[8*k +: 8];
                send_byte(word[8*k +: 8], w);
                waits_total += w;
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(sum, w); waits_total += w;
`endif
    endtask

    task automatic read_mem(input logic [5:0] a, input logic [31:0] exp, input string name);
        Inst_addr = a;
        #1;
        tests++;
        if (Inst_data !== exp) begin
            fails++;
            $display("FAIL %s addr=%0d got=%08h exp=%08h", name, a, Inst_data, exp);
        end
    endtask

    task automatic test_reset;
        #3;
        tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_hold got=%b exp=1", cpu_hold); end
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", rx_ready); end
        tests++; if ({load_done, load_err} !== 2'b00) begin fails++; $display("FAIL rst_flags got=%b exp=00", {load_done, load_err}); end
        tests++; if (words_loaded !== 7'd0) begin fails++; $display("FAIL rst_words got=%0d exp=0", words_loaded); end
        @(negedge clk); Rst = 1'b0; #1;
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after got=%b exp=1", rx_ready); end
    endtask

    task automatic test_load;
        int w;
        sb(8'h11); sb(8'h22);
        tests++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL garbage hold=%b done=%b exp 1/0", cpu_hold, load_done); end
        img[0] = 32'hE3A00001; img[1] = 32'hE3A00002;
        send_frame(8'h02, 2, w);
        rx_valid = 1'b0;
        tests++; if (cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin fails++; $display("FAIL commit_cycle hold=%b ready=%b exp 1/0", cpu_hold, rx_ready); end
        tests++; if (words_loaded !== 7'd2) begin fails++; $display("FAIL load_words got=%0d exp=2", words_loaded); end
        @(posedge clk); #1;
        tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL release got=%b exp=0", cpu_hold); end
        tests++; if (load_done !== 1'b1 || load_err !== 1'b0) begin fails++; $display("FAIL load_flags done=%b err=%b exp 1/0", load_done, load_err); end
        read_mem(6'd0, 32'hE3A00001, "load_mem0");
        read_mem(6'd1, 32'hE3A00002, "load_mem1");
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_bad_sum;
        int w;
        sb(8'hA5); sb(8'h02);
        sb(8'h01); sb(8'h00); sb(8'hA0); sb(8'hE3);
        sb(8'h02); sb(8'h00); sb(8'hA0); sb(8'hE3);
        sb(8'h5A);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL bad_sum err=%b hold=%b done=%b exp 1/1/0", load_err, cpu_hold, load_done); end
        send_frame(8'h02, 2, w);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (load_err !== 1'b0 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL sum_recover err=%b done=%b hold=%b exp 0/1/0", load_err, load_done, cpu_hold); end
    endtask
`endif

    task automatic test_resync;
        sb(8'hA5);
        tests++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL resync hold=%b done=%b exp 1/0", cpu_hold, load_done); end
    endtask

    task automatic test_oversize;
        int w;
        sb(8'h41);
        rx_valid = 1'b0;
        tests++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin fails++; $display("FAIL oversize err=%b hold=%b exp 1/1", load_err, cpu_hold); end
        tests++; if (words_loaded !== 7'd2) begin fails++; $display("FAIL oversize_words got=%0d exp=2", words_loaded); end
        read_mem(6'd0, 32'hE3A00001, "oversize_mem0");
        img[0] = 32'h12345678;
        send_frame(8'h01, 1, w);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (load_err !== 1'b0 || load_done !== 1'b1 || words_loaded !== 7'd1) begin fails++; $display("FAIL err_recover err=%b done=%b words=%0d exp 0/1/1", load_err, load_done, words_loaded); end
        read_mem(6'd0, 32'h12345678, "recover_mem0");
        read_mem(6'd1, 32'hE3A00002, "kept_mem1");
    endtask

    task automatic test_full;
        int w;
        for (int i = 0; i < 64; i++) img[i] = {8'(i), 8'(~i), 8'hC0, 8'(i * 3)};
        send_frame(8'h00, 64, w);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (words_loaded !== 7'd64 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL full words=%0d done=%b hold=%b exp 64/1/0", words_loaded, load_done, cpu_hold); end
        read_mem(6'd0,  32'h00FFC000, "full_mem0");
        read_mem(6'd63, 32'h3FC0C0BD, "full_mem63");
    endtask

    task automatic test_reset_mid;
        sb(8'hA5); sb(8'h02);
        sb(8'hDD); sb(8'hCC); sb(8'hBB); sb(8'hAA); sb(8'h11);
        rx_valid = 1'b0;
        Rst = 1'b1;
        #2;
        tests++; if (cpu_hold !== 1'b1 || rx_ready !== 1'b0 || words_loaded !== 7'd0) begin fails++; $display("FAIL mid_reset hold=%b ready=%b words=%0d exp 1/0/0", cpu_hold, rx_ready, words_loaded); end
        read_mem(6'd0, 32'hAABBCCDD, "mid_reset_mem0");
        @(posedge clk); @(negedge clk); Rst = 1'b0; #1;
        sb(8'h02);
        rx_valid = 1'b0;
        tests++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL mid_reset_sync hold=%b done=%b exp 1/0", cpu_hold, load_done); end
    endtask

    task automatic test_back_to_back;
        int wt, w;
        img[0] = 32'hCAFEF00D; img[1] = 32'h01234567;
        send_frame(8'h02, 2, wt);
        send_byte(8'h11, w);
        rx_valid = 1'b0;
        tests++; if (wt !== 0) begin fails++; $display("FAIL b2b_frame_waits got=%0d exp=0", wt); end
        tests++; if (w !== 1) begin fails++; $display("FAIL b2b_commit_wait got=%0d exp=1", w); end
        tests++; if (cpu_hold !== 1'b0 || load_done !== 1'b1) begin fails++; $display("FAIL b2b_run hold=%b done=%b exp 0/1", cpu_hold, load_done); end
        read_mem(6'd0, 32'hCAFEF00D, "b2b_mem0");
        read_mem(6'd1, 32'h01234567, "b2b_mem1");
    endtask

    initial begin
        test_reset;
        test_load;
`ifdef INST_LOADER_CHECKSUM_EN
        test_bad_sum;
`endif
        test_resync;
        test_oversize;
        test_full;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
